// File: rtl/mpmc11_pkg.sv
// Shared types for the mpmc11 controller: controller FSM states, read-arbiter
// states and a wraparound first-set helper used for selection.
package mpmc11_pkg;

  localparam int MAX_CH = 32;

  typedef enum logic [2:0] {
    IDLE,
    REFRESH,
    ACTIVATE,
    READ,
    WRITE,
    PRECHARGE
  } mpmc11_state_t;

  typedef enum logic [1:0] {
    ARB,
    GNT,
    COOL
  } mpmc11_rdarb_state_t;

  // First set bit of vec scanning last+1 .. n-1 then 0 .. last (modulo n).
  function automatic int rr_pick(input logic [MAX_CH-1:0] vec, input int last, input int n);
    int         res;
    bit         hit;
    logic [4:0] idx;
    res = 0;
    hit = 1'b0;
    for (int k = 0; k < MAX_CH; k++) begin
      idx = 5'((last + 1 + k) % n);
      if (k < n && !hit && vec[idx]) begin
        res = int'(idx);
        hit = 1'b1;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/mpmc11_rr_pick.sv
// Combinational wraparound first-set finder: lowest set bit above last_i,
// otherwise lowest set bit overall. last_i = NCH-1 gives fixed priority.
module mpmc11_rr_pick #(
  parameter int NCH = 9,
  parameter int CW  = 4
) (
  input  logic [NCH-1:0] vec_i,
  input  logic [CW-1:0]  last_i,
  output logic [CW-1:0]  idx_o,
  output logic           found_o
);

  logic [NCH-1:0] above;
  logic [NCH-1:0] src;

  // NOTE: every output of a combinational block gets a default before any
  // conditional assignment, otherwise a latch is inferred.
  always_comb begin
    above = '0;
    for (int i = 0; i < NCH; i++) begin
      above[i] = (i > int'(last_i));
    end
    src     = (|(vec_i & above)) ? (vec_i & above) : vec_i;
    idx_o   = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (src[i]) idx_o = CW'(i);
    end
    found_o = |vec_i;
  end

endmodule

// File: rtl/mpmc11_rd_fifo_arb.sv
// Read-FIFO candidate register and single-grant arbiter (req/ack to the controller).
// Optional per-channel starvation aging is enabled with `define MPMC11_RDARB_AGE_EN.
module mpmc11_rd_fifo_arb
  import mpmc11_pkg::*;
#(
  parameter  int NCH     = 9,
  parameter  int RR      = 1,
  parameter  int AGE_W   = 4,
  parameter  int AGE_LIM = 12,
  localparam int CW      = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  mpmc11_state_t state,
  input  logic [NCH-1:0] empty,
  input  logic [NCH-1:0] rd_rst_busy,
  input  logic          calib_complete,
  input  logic          ack,
  output logic [NCH-1:0] rd,
  output logic [NCH-1:0] gnt,
  output logic          gnt_v,
  output logic [CW-1:0] gnt_ch,
  output logic [NCH-1:0] starve
);

  localparam logic [CW-1:0] LAST_FP = CW'(NCH - 1);

  logic [NCH-1:0]      rd_d;
  logic [NCH-1:0]      rd_q;
  logic [NCH-1:0]      gnt_q;
  logic                gnt_v_q;
  logic [CW-1:0]       gnt_ch_q;
  logic [CW-1:0]       last_q;
  mpmc11_rdarb_state_t fsm_q;

  logic [CW-1:0]       pick_last;
  logic [CW-1:0]       pick_idx;
  logic                pick_found;
  logic [CW-1:0]       sel_idx;
  logic                gnt_lost;
  logic [NCH-1:0]      starve_vec;

  assign rd_d      = (state == IDLE && calib_complete) ? (~empty & ~rd_rst_busy) : '0;
  assign gnt_lost  = |(gnt_q & (empty | rd_rst_busy));
  assign pick_last = (RR != 0) ? last_q : LAST_FP;

  mpmc11_rr_pick #(
    .NCH(NCH),
    .CW (CW)
  ) u_pick (
    .vec_i  (rd_q),
    .last_i (pick_last),
    .idx_o  (pick_idx),
    .found_o(pick_found)
  );

`ifdef MPMC11_RDARB_AGE_EN
  logic [MAX_CH-1:0] starve_cand;
  logic [AGE_W-1:0]  age_q [NCH];
  logic [AGE_W-1:0]  age_d [NCH];
  logic [NCH-1:0]    starve_q;
  logic [NCH-1:0]    starve_d;

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      age_d[i] = age_q[i];
      if (!calib_complete || !rd_q[i] || (gnt_v_q && ack && gnt_q[i])) begin
        age_d[i] = '0;
      end else if (!gnt_q[i] && age_q[i] != {AGE_W{1'b1}}) begin
        age_d[i] = age_q[i] + 1'b1;
      end
      starve_d[i] = (age_d[i] >= AGE_W'(AGE_LIM));
    end
  end

  // NOTE: the age array is reset like any other register; starve is derived
  // from it and must read zero straight out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) age_q[i] <= '0;
      starve_q <= '0;
    end else begin
      age_q    <= age_d;
      starve_q <= starve_d;
    end
  end

  assign starve_vec = starve_q;
`else
  localparam logic AGE_CFG_OK = (AGE_LIM < (1 << AGE_W));
  // Without aging the starve vector is a constant zero for any legal configuration.
  assign starve_vec = {NCH{1'b0}} & {NCH{AGE_CFG_OK}};
`endif

  // A starving, still-readable channel overrides the normal pick.
  always_comb begin
    sel_idx = pick_idx;
`ifdef MPMC11_RDARB_AGE_EN
    starve_cand             = '0;
    starve_cand[NCH-1:0]    = starve_vec & rd_q;
    if (|starve_cand) sel_idx = CW'(rr_pick(starve_cand, NCH - 1, NCH));
`endif
  end

  // NOTE: sequential state uses <= so every register samples pre-edge values,
  // independent of statement order inside the block.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q     <= '0;
      gnt_q    <= '0;
      gnt_v_q  <= 1'b0;
      gnt_ch_q <= '0;
      last_q   <= LAST_FP;
      fsm_q    <= ARB;
    end else begin
      rd_q <= rd_d;
      if (!calib_complete) begin
        gnt_q   <= '0;
        gnt_v_q <= 1'b0;
        fsm_q   <= ARB;
      end else begin
        case (fsm_q)
          ARB: begin
            if (pick_found) begin
              gnt_q    <= {{(NCH-1){1'b0}}, 1'b1} << sel_idx;
              gnt_ch_q <= sel_idx;
              gnt_v_q  <= 1'b1;
              fsm_q    <= GNT;
            end
          end
          GNT: begin
            if (ack) begin
              gnt_q   <= '0;
              gnt_v_q <= 1'b0;
              last_q  <= gnt_ch_q;
              fsm_q   <= COOL;
            end else if (gnt_lost) begin
              gnt_q   <= '0;
              gnt_v_q <= 1'b0;
              fsm_q   <= ARB;
            end
          end
          // One idle cycle lets the FIFO empty flag catch up with the last read.
          COOL:    fsm_q <= ARB;
          default: fsm_q <= ARB;
        endcase
      end
    end
  end

  assign rd     = rd_q;
  assign gnt    = gnt_q;
  assign gnt_v  = gnt_v_q;
  assign gnt_ch = gnt_ch_q;
  assign starve = starve_vec;

endmodule

// File: tb/tb_mpmc11_rd_fifo_arb.sv
// Bench for mpmc11_rd_fifo_arb: a round-robin and a fixed-priority instance
// share stimulus and are compared each cycle against a behavioural model.
module tb_mpmc11_rd_fifo_arb;
  import mpmc11_pkg::*;

  localparam int N       = 9;
  localparam int CW      = 4;
  localparam int AGE_LIM = 12;
  localparam int AGE_MAX = 15;
  localparam int P_ARB   = 0;
  localparam int P_GNT   = 1;
  localparam int P_COOL  = 2;

  logic          clk = 1'b0;
  logic          rst;
  mpmc11_state_t state;
  logic [N-1:0]  empty;
  logic [N-1:0]  busy;
  logic          calib;
  logic          ack;

  logic [N-1:0]  r_rd, r_gnt, r_starve, f_rd, f_gnt, f_starve;
  logic          r_gnt_v, f_gnt_v;
  logic [CW-1:0] r_gnt_ch, f_gnt_ch;

  always #5 clk = ~clk;

  mpmc11_rd_fifo_arb #(.NCH(N), .RR(1), .AGE_W(4), .AGE_LIM(AGE_LIM)) u_rr (
    .clk(clk), .rst(rst), .state(state), .empty(empty), .rd_rst_busy(busy),
    .calib_complete(calib), .ack(ack), .rd(r_rd), .gnt(r_gnt), .gnt_v(r_gnt_v),
    .gnt_ch(r_gnt_ch), .starve(r_starve)
  );

  mpmc11_rd_fifo_arb #(.NCH(N), .RR(0), .AGE_W(4), .AGE_LIM(AGE_LIM)) u_fp (
    .clk(clk), .rst(rst), .state(state), .empty(empty), .rd_rst_busy(busy),
    .calib_complete(calib), .ack(ack), .rd(f_rd), .gnt(f_gnt), .gnt_v(f_gnt_v),
    .gnt_ch(f_gnt_ch), .starve(f_starve)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Model: granted channel (-1 = none), phase, last acked channel, ages.
  typedef struct {
    int gch;
    int phase;
    int last;
    int age [N];
  } mdl_t;

  mdl_t         m [2];
  logic [N-1:0] m_rd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick_ch(input logic [N-1:0] v, input int start);
    for (int k = 0; k < N; k++) begin
      if (v[(start + k) % N]) return (start + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_starve(input int d);
    logic [N-1:0] s;
    s = '0;
    for (int i = 0; i < N; i++) s[i] = (m[d].age[i] >= AGE_LIM);
    return s;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m[d].gch   = -1;
      m[d].phase = P_ARB;
      m[d].last  = N - 1;
      for (int i = 0; i < N; i++) m[d].age[i] = 0;
    end
    m_rd = '0;
  endtask

  task automatic model_step();
    logic [N-1:0] rd_new, old_st, cand;
    int g, start;
    rd_new = (calib && state == IDLE) ? (~empty & ~busy) : '0;
    for (int d = 0; d < 2; d++) begin
      g      = m[d].gch;
      old_st = exp_starve(d);
`ifdef MPMC11_RDARB_AGE_EN
      for (int i = 0; i < N; i++) begin
        if (!calib || !m_rd[i] || (m[d].phase == P_GNT && ack && g == i)) m[d].age[i] = 0;
        else if (g != i && m[d].age[i] < AGE_MAX) m[d].age[i] = m[d].age[i] + 1;
      end
`endif
      if (!calib) begin
        m[d].gch   = -1;
        m[d].phase = P_ARB;
      end else if (m[d].phase == P_ARB) begin
        if (m_rd != '0) begin
          cand  = m_rd & old_st;
          start = (d == 0) ? (m[d].last + 1) % N : 0;
          m[d].gch   = (cand != '0) ? pick_ch(cand, 0) : pick_ch(m_rd, start);
          m[d].phase = P_GNT;
        end
      end else if (m[d].phase == P_GNT) begin
        if (ack) begin
          m[d].last  = g;
          m[d].gch   = -1;
          m[d].phase = P_COOL;
        end else if (empty[g] || busy[g]) begin
          m[d].gch   = -1;
          m[d].phase = P_ARB;
        end
      end else begin
        m[d].phase = P_ARB;
      end
    end
    m_rd = rd_new;
  endtask

  task automatic check_all();
    logic [N-1:0]  o_rd, o_gnt, o_st, e_gnt, one;
    logic          o_v;
    logic [CW-1:0] o_ch;
    string         pre;
    one = 1;
    for (int d = 0; d < 2; d++) begin
      pre   = (d == 0) ? "rr" : "fp";
      o_rd  = (d == 0) ? r_rd     : f_rd;
      o_gnt = (d == 0) ? r_gnt    : f_gnt;
      o_v   = (d == 0) ? r_gnt_v  : f_gnt_v;
      o_ch  = (d == 0) ? r_gnt_ch : f_gnt_ch;
      o_st  = (d == 0) ? r_starve : f_starve;
      e_gnt = (m[d].gch >= 0) ? (one << m[d].gch) : '0;
      chk({pre, "_rd"},     32'(o_rd),  32'(m_rd));
      chk({pre, "_gnt"},    32'(o_gnt), 32'(e_gnt));
      chk({pre, "_gnt_v"},  32'(o_v),   32'(m[d].gch >= 0));
      chk({pre, "_starve"}, 32'(o_st),  32'(exp_starve(d)));
      if (m[d].gch >= 0) chk({pre, "_gnt_ch"}, 32'(o_ch), 32'(m[d].gch));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst) model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic wait_gnt(input int d, input int budget);
    bit got;
    got = (d == 0) ? r_gnt_v : f_gnt_v;
    for (int k = 0; k < budget && !got; k++) begin
      tick();
      got = (d == 0) ? r_gnt_v : f_gnt_v;
    end
    chk("wait_gnt", 32'(got), 32'd1);
  endtask

  task automatic pulse_ack();
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    chk("rst_async_gnt_v",  32'(r_gnt_v),  32'd0);
    chk("rst_async_gnt_ch", 32'(r_gnt_ch), 32'd0);
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst   = 1'b1;
    state = IDLE;
    empty = '1;
    busy  = '0;
    calib = 1'b0;
    ack   = 1'b0;
    model_reset();
    tick();
    tick();
    rst   = 1'b0;
    calib = 1'b1;

    // Candidate gating and two-edge grant latency.
    empty = 9'h1FB;
    tick();
    chk("gate_rd_edge1",   32'(r_rd),    32'h004);
    chk("gate_gntv_edge1", 32'(r_gnt_v), 32'd0);
    tick();
    chk("gate_gnt_edge2",  32'(r_gnt),    32'h004);
    chk("gate_ch_edge2",   32'(r_gnt_ch), 32'd2);
    chk("gate_gntv_edge2", 32'(r_gnt_v),  32'd1);
    pulse_ack();
    state = READ;
    repeat (4) tick();
    chk("gate_notidle_rd",  32'(r_rd),    32'd0);
    chk("gate_notidle_gnt", 32'(r_gnt_v), 32'd0);

    // Asynchronous reset while holding a grant on ch3.
    state = IDLE;
    empty = 9'h1F7;
    wait_gnt(0, 10);
    chk("pre_rst_ch", 32'(r_gnt_ch), 32'd3);
    do_reset();

    // Round-robin wrap between ch0 and ch8; fixed priority always ch0.
    empty = 9'h0FE;
    for (int k = 0; k < 4; k++) begin
      wait_gnt(0, 10);
      chk("rr_wrap_ch", 32'(r_gnt_ch), (k % 2 == 0) ? 32'd0 : 32'd8);
      chk("fp_prio_ch", 32'(f_gnt_ch), 32'd0);
      pulse_ack();
    end

    // Abort on ch5, then ack coinciding with the abort condition.
    empty = 9'h1DF;
    wait_gnt(0, 10);
    chk("abort_pre_ch", 32'(r_gnt_ch), 32'd5);
    empty = 9'h1FF;
    tick();
    chk("abort_gntv", 32'(r_gnt_v), 32'd0);
    empty = 9'h1DF;
    wait_gnt(0, 10);
    ack   = 1'b1;
    empty = 9'h1FF;
    tick();
    ack   = 1'b0;
    chk("ack_vs_abort_gntv", 32'(r_gnt_v), 32'd0);
    empty = 9'h1B7;
    wait_gnt(0, 10);
    chk("ack_wins_last_rr", 32'(r_gnt_ch), 32'd6);
    chk("ack_wins_last_fp", 32'(f_gnt_ch), 32'd3);
    pulse_ack();

    // Long hold on ch0 while ch6 waits.
    do_reset();
    empty = 9'h1BE;
    wait_gnt(1, 10);
    chk("age_first_ch", 32'(f_gnt_ch), 32'd0);
    repeat (20) tick();
`ifdef MPMC11_RDARB_AGE_EN
    chk("age_starve6", 32'(f_starve[6]), 32'd1);
`else
    chk("age_starve_off", 32'(f_starve), 32'd0);
`endif
    pulse_ack();
    wait_gnt(1, 10);
`ifdef MPMC11_RDARB_AGE_EN
    chk("age_override_ch", 32'(f_gnt_ch), 32'd6);
`else
    chk("age_override_ch", 32'(f_gnt_ch), 32'd0);
`endif
    pulse_ack();
    repeat (3) tick();

    // Randomised traffic against the model.
    for (int c = 0; c < 600; c++) begin
      calib = ($urandom_range(0, 99) < 3) ? 1'b0 : 1'b1;
      state = ($urandom_range(0, 99) < 85) ? IDLE : mpmc11_state_t'(3'($urandom_range(1, 5)));
      if ($urandom_range(0, 99) < 30) empty[$urandom_range(0, N - 1)] ^= 1'b1;
      busy  = '0;
      if ($urandom_range(0, 99) < 5) busy[$urandom_range(0, N - 1)] = 1'b1;
      ack   = ($urandom_range(0, 99) < 25);
      tick();
    end
    ack = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mpmc11_rd_fifo_arb.md
Name: mpmc11_rd_fifo_arb

Overview:
Parametrised successor to the controller's read-FIFO candidate generator. Registers a per-channel "could be read" vector while the controller is in IDLE, then arbitrates it down to a single held grant with a req/ack handshake toward the controller FSM. Selection is fixed-priority or round-robin, and the grant is aborted if the granted FIFO becomes unreadable. Sits between the per-port read FIFOs and mpmc11_fta.

Parameters:
NCH, 9, number of read-FIFO channels (2..32)
RR, 1, 1 = round-robin selection, 0 = fixed priority (lowest index wins)
AGE_W, 4, width of per-channel age counters (used only with the optional feature)
AGE_LIM, 12, age value at which a channel is promoted (must be < 2**AGE_W)

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
state  input  mpmc11_state_t  controller state; candidates are formed only in mpmc11_pkg::IDLE
empty  input  NCH  per-FIFO empty flag
rd_rst_busy  input  NCH  per-FIFO reset-busy flag
calib_complete  input  1  memory calibration done
ack  input  1  controller has accepted the grant (single-cycle pulse)
rd  output  NCH  registered candidate vector
gnt  output  NCH  one-hot grant, held until ack or abort
gnt_v  output  1  grant valid
gnt_ch  output  CW  binary index of the granted channel; CW = max(1, $clog2(NCH))
starve  output  NCH  channel age has reached AGE_LIM (all zeros when the feature is off)

Behaviour:
- Reset (asynchronous, active-high; may assert at any cycle): rd=0, gnt=0, gnt_v=0, gnt_ch=0, starve=0, last=NCH-1, FSM=ARB, ages=0.
- Candidate register (every cycle): rd[i] <= (state==IDLE) && !empty[i] && !rd_rst_busy[i] && calib_complete. When state != IDLE, rd <= 0.
- FSM states: ARB, GNT, COOL.
  - ARB: if |rd, select channel s, load gnt=1<<s, gnt_ch=s, gnt_v=1 on the next edge, go to GNT. If rd==0, stay in ARB.
  - GNT: outputs are held stable.
    - ack=1: clear gnt/gnt_v on the next edge, set last=gnt_ch, go to COOL.
    - Else if the granted channel becomes unreadable (empty or rd_rst_busy high): abort. Clear gnt/gnt_v, leave last unchanged, go to ARB.
    - If ack and the abort condition occur in the same cycle, ack wins.
  - COOL: exactly one cycle, no grant, so the FIFO empty flag can update. Then go to ARB.
- calib_complete=0 in any state: on the next edge, gnt, gnt_v, rd and starve are cleared and the FSM goes to ARB.
- Selection:
  - RR=0: lowest set index of rd.
  - RR=1: first set index scanning last+1 .. NCH-1, then wrapping to 0 .. last. Index arithmetic is modulo NCH, not 2**CW.
- Latency: an eligible FIFO in IDLE produces rd at edge+1 and gnt_v at edge+2.
- ack while gnt_v=0 is ignored.
- Invariants: gnt is always one-hot or zero. gnt_v == |gnt. gnt_ch is valid only when gnt_v=1.

Optional Feature:
MPMC11_RDARB_AGE_EN
- Defined:
  - Per-channel AGE_W-bit counter increments (saturating) on each cycle where rd[i]=1 and channel i is not granted.
  - Counter clears on ack of channel i and whenever rd[i]=0.
  - starve[i] = (age[i] >= AGE_LIM), registered.
  - In ARB, if any starve bit is set, the lowest-index starving channel overrides RR/priority selection.
- Not defined: no counters are instantiated, starve is tied to 0, and selection is purely by RR.

Decomposition:
- mpmc11_pkg: add the mpmc11_rdarb_state_t enum (ARB, GNT, COOL) and the function rr_pick(vec, last, n) returning the index. mpmc11_state_t is reused.
- Sub-module mpmc11_rr_pick: combinational, NCH-wide, wraparound first-set finder with a found flag. It is instantiated once in this block and also for fixed priority (last=NCH-1).

Test Plan:
- Reset mid-GNT: with gnt_v=1 on ch3, assert rst for 1 cycle -> all outputs 0 the same cycle (asynchronous), FSM=ARB, last=8.
- Candidate gating: NCH=9, empty=9'h1FB, state=IDLE, calib=1 -> rd=9'h004 after 1 edge, gnt=9'h004, gnt_ch=2, gnt_v=1 after 2 edges. Same stimulus with state!=IDLE -> rd=0, no grant.
- Round-robin wrap: empty=9'h0FE (ch0 and ch8 readable), ack each grant -> grant order ch0, ch8, ch0, ch8. Exactly one COOL cycle with gnt_v=0 between grants.
- Fixed priority (RR=0): the same stimulus -> ch0 is granted every time.
- Abort: granted ch5, raise empty[5] with no ack -> gnt_v=0 next edge, last unchanged. Simultaneous ack + empty[5] -> treated as ack, last=5.
- Aging (macro on, AGE_LIM=12, RR=0): ch0 and ch6 continuously readable, ch0 acked after 20-cycle holds -> starve[6]=1 once its age reaches 12. ch6 wins the next ARB, and age[6] clears on its ack.
